// File: rtl/rtc_control_module.sv
// DS1302 sequencer: writes WP/hour/min/sec once, then reads sec/min/hour every REFRESH_CNT cycles.
// Each command is held until func_done_sig and followed by an idle gap that lasts until done drops.
module rtc_control_module #(
    parameter logic [7:0]  INIT_SEC    = 8'h00,
    parameter logic [7:0]  INIT_MIN    = 8'h00,
    parameter logic [7:0]  INIT_HOUR   = 8'h12,
    parameter logic [31:0] REFRESH_CNT = 32'd1_000_000
) (
    input  logic       CLK,
    input  logic       RSTn,
    output logic [1:0] func_start_sig,
    output logic [7:0] words_addr,
    output logic [7:0] write_data,
    input  logic [7:0] read_data,
    input  logic       func_done_sig,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic       time_valid,
    output logic       init_done
);

    typedef enum logic [3:0] {
        S_W_WP, S_W_HOUR, S_W_MIN, S_W_SEC, S_WAIT, S_R_SEC, S_R_MIN, S_R_HOUR, S_UPD
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  start_q, start_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic        init_q, init_d;

    logic [1:0]  cmd_start;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic        unused_rd7;

    assign unused_rd7 = read_data[7];

    always_comb begin
        cmd_start = 2'b10;
        cmd_addr  = 8'h00;
        cmd_data  = 8'h00;
        case (state_q)
            S_W_WP:   begin cmd_addr = 8'h8E; cmd_data = 8'h00; end
            S_W_HOUR: begin cmd_addr = 8'h84; cmd_data = INIT_HOUR; end
            S_W_MIN:  begin cmd_addr = 8'h82; cmd_data = INIT_MIN; end
            S_W_SEC:  begin cmd_addr = 8'h80; cmd_data = {1'b0, INIT_SEC[6:0]}; end
            S_R_SEC:  begin cmd_start = 2'b01; cmd_addr = 8'h81; end
            S_R_MIN:  begin cmd_start = 2'b01; cmd_addr = 8'h83; end
            S_R_HOUR: begin cmd_start = 2'b01; cmd_addr = 8'h85; end
            default:  cmd_start = 2'b00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        init_d  = init_q;
        case (state_q)
            S_WAIT: begin
                // Issue the first read directly on exit so the gap from UPD is REFRESH_CNT+1.
                if (cnt_q == REFRESH_CNT - 32'd1) begin
                    state_d = S_R_SEC;
                    start_d = 2'b01;
                    addr_d  = 8'h81;
                    data_d  = 8'h00;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_UPD: begin
                state_d = S_WAIT;
                cnt_d   = 32'd0;
            end
            S_W_WP, S_W_HOUR, S_W_MIN, S_W_SEC, S_R_SEC, S_R_MIN, S_R_HOUR: begin
                if (start_q == 2'b00) begin
                    // A done still held from the previous command extends the idle gap.
                    if (!func_done_sig) begin
                        start_d = cmd_start;
                        addr_d  = cmd_addr;
                        data_d  = cmd_data;
                    end
                end else if (func_done_sig) begin
                    start_d = 2'b00;
                    state_d = state_t'(state_q + 4'd1);
                    case (state_q)
                        S_W_SEC: begin
                            init_d = 1'b1;
                            cnt_d  = 32'd0;
                        end
                        S_R_SEC:  sec_d  = {1'b0, read_data[6:0]};
                        S_R_MIN:  min_d  = {1'b0, read_data[6:0]};
                        S_R_HOUR: hour_d = {2'b00, read_data[5:0]};
                        default:  ;
                    endcase
                end
            end
            default: begin
                state_d = S_W_WP;
                start_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_W_WP;
            start_q <= 2'b00;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            cnt_q   <= 32'd0;
            sec_q   <= 8'h00;
            min_q   <= 8'h00;
            hour_q  <= 8'h00;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            init_q  <= init_d;
        end
    end

    assign func_start_sig = start_q;
    assign words_addr     = addr_q;
    assign write_data     = data_q;
    assign sec_bcd        = sec_q;
    assign min_bcd        = min_q;
    assign hour_bcd       = hour_q;
    assign time_valid     = (state_q == S_UPD);
    assign init_done      = init_q;

endmodule
